// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter
// Sequencer and two-port arbiter in front of the single memory_unit.
// The fetch and data requesters share one memory. Each granted access is
// captured into Mar/Mdr/RW/WordSel. The block then waits for MFC and returns
// read data with a one-cycle ack.
//
// Optional feature: define MEM_TIMEOUT_EN to bound the wait for MFC to
// TIMEOUT ACCESS cycles. On expiry the access is acked with err=1.
//
// Ports
//   Clk, Clr              clock, synchronous active-high reset
//   F_req/F_addr          fetch requester (always a word read)
//   D_req/D_addr/D_rw/
//   D_size/D_wdata        data requester (size 00 byte, 01 half, 10 word)
//   F_ack/D_ack           one-cycle completion pulses
//   rdata, err            read data / error flag, valid with an ack
//   busy                  high whenever not IDLE
//   RamEn/RW/Mar/Mdr/
//   WordSel               memory controls
//   RamOut, MFC           memory read data / function complete
module mem_access_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        F_req,
  input  logic [31:0] F_addr,
  input  logic        D_req,
  input  logic [31:0] D_addr,
  input  logic        D_rw,
  input  logic [1:0]  D_size,
  input  logic [31:0] D_wdata,
  output logic        F_ack,
  output logic        D_ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy,
  output logic        RamEn,
  output logic        RW,
  output logic [31:0] Mar,
  output logic [31:0] Mdr,
  output logic [1:0]  WordSel,
  input  logic [31:0] RamOut,
  input  logic        MFC
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("mem_access_arbiter: TIMEOUT must be in 1..255");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] mar_q, mar_d;
  logic [31:0] mdr_q, mdr_d;
  logic        rw_q, rw_d;
  logic [1:0]  wsel_q, wsel_d;
  logic        port_q, port_d;    // granted port: 1 = data, 0 = fetch
  logic        last_q, last_d;    // last served port: 1 = data, 0 = fetch
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        grant_data;
  logic        misaligned;
  logic        timeout_hit;

  // Ties go to whichever port was not served last.
  assign grant_data = D_req && (!F_req || !last_q);

  always_comb begin
    misaligned = 1'b0;
    case (wsel_q)
      2'b01:   misaligned = mar_q[0];
      2'b10:   misaligned = |mar_q[1:0];
      2'b11:   misaligned = 1'b1;
      default: misaligned = 1'b0;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] cnt_q, cnt_d;

  // cnt_q counts ACCESS cycles already spent. The cycle where the count
  // would reach TIMEOUT is the last one allowed.
  assign timeout_hit = (state_q == ACCESS) && (cnt_q == TMO_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == SETUP)       cnt_d = 8'd0;
    else if (state_q == ACCESS) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge Clk) begin
    if (Clr) cnt_q <= 8'd0;
    else     cnt_q <= cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register and datapath flops.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      state_q <= IDLE;
      mar_q   <= 32'd0;
      mdr_q   <= 32'd0;
      rw_q    <= 1'b0;
      wsel_q  <= 2'b00;
      port_q  <= 1'b0;
      last_q  <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      rw_q    <= rw_d;
      wsel_q  <= wsel_d;
      port_q  <= port_d;
      last_q  <= last_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (F_req || D_req) state_d = SETUP;
      SETUP:   state_d = misaligned ? DONE : ACCESS;
      ACCESS:  if (MFC || timeout_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath capture. MFC has priority over a same-cycle timeout.
  always_comb begin
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    rw_d    = rw_q;
    wsel_d  = wsel_q;
    port_d  = port_q;
    last_d  = last_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (F_req || D_req) begin
          port_d = grant_data;
          if (grant_data) begin
            mar_d  = D_addr;
            mdr_d  = D_wdata;
            rw_d   = D_rw;
            wsel_d = D_size;
          end else begin
            mar_d  = F_addr;
            mdr_d  = 32'd0;
            rw_d   = 1'b1;
            wsel_d = 2'b10;
          end
        end
      end
      SETUP: begin
        err_d   = misaligned;
        rdata_d = 32'd0;
      end
      ACCESS: begin
        if (MFC) begin
          rdata_d = rw_q ? RamOut : 32'd0;
          err_d   = 1'b0;
        end else if (timeout_hit) begin
          rdata_d = 32'd0;
          err_d   = 1'b1;
        end
      end
      DONE:    last_d = port_q;
      default: ;
    endcase
  end

  // Outputs.
  always_comb begin
    F_ack   = (state_q == DONE) && !port_q;
    D_ack   = (state_q == DONE) &&  port_q;
    err     = (state_q == DONE) &&  err_q;
    rdata   = rdata_q;
    busy    = (state_q != IDLE);
    RamEn   = (state_q == ACCESS);
    RW      = rw_q;
    Mar     = mar_q;
    Mdr     = mdr_q;
    WordSel = wsel_q;
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Randomised self-checking bench for mem_access_arbiter. A transaction-level
// model predicts the grant, captured controls, error and read data of each
// access from the arbitration and alignment rules.
module tb_mem_access_arbiter;

  logic        Clk = 1'b0;
  logic        Clr = 1'b1;
  logic        F_req = 1'b0;
  logic [31:0] F_addr = '0;
  logic        D_req = 1'b0;
  logic [31:0] D_addr = '0;
  logic        D_rw = 1'b0;
  logic [1:0]  D_size = '0;
  logic [31:0] D_wdata = '0;
  logic        F_ack, D_ack, err, busy, RamEn, RW;
  logic [31:0] rdata, Mar, Mdr;
  logic [1:0]  WordSel;
  logic [31:0] RamOut = '0;
  logic        MFC = 1'b0;

  int total = 0;
  int bad   = 0;
  bit last_data = 1'b0;   // model: 1 when the data port was served last

  mem_access_arbiter #(.TIMEOUT(4)) dut (
    .Clk(Clk), .Clr(Clr),
    .F_req(F_req), .F_addr(F_addr),
    .D_req(D_req), .D_addr(D_addr), .D_rw(D_rw), .D_size(D_size), .D_wdata(D_wdata),
    .F_ack(F_ack), .D_ack(D_ack), .rdata(rdata), .err(err), .busy(busy),
    .RamEn(RamEn), .RW(RW), .Mar(Mar), .Mdr(Mdr), .WordSel(WordSel),
    .RamOut(RamOut), .MFC(MFC)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // One complete access. The call starts and ends 1 time unit after a rising
  // edge, with the DUT in IDLE. dly is the number of ACCESS cycles before MFC.
  task automatic run_txn(input bit f, input bit d, input logic [31:0] fa,
                         input logic [31:0] da, input bit drw, input logic [1:0] dsz,
                         input logic [31:0] wd, input int dly, input logic [31:0] ro,
                         input string tag);
    bit gd, mis, erw;
    logic [31:0] ea, em, erd;
    logic [1:0]  ews;
    int nb;
    gd  = d && (!f || !last_data);
    ea  = gd ? da : fa;
    em  = gd ? wd : 32'd0;
    erw = gd ? drw : 1'b1;
    ews = gd ? dsz : 2'd2;
    nb  = (ews == 2'd0) ? 1 : (ews == 2'd1) ? 2 : 4;
    mis = (ews == 2'd3) || ((ea % nb) != 0);
    erd = (mis || !erw) ? 32'd0 : ro;

    F_req = f; D_req = d; F_addr = fa; D_addr = da;
    D_rw = drw; D_size = dsz; D_wdata = wd;
    @(negedge Clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL %s idle_busy got=%b exp=0", tag, busy); end
    step();
    // The losing port withdraws, and the winner's fields are scrambled: neither may matter now.
    if (gd) F_req = 1'b0; else D_req = 1'b0;
    F_addr = $urandom; D_addr = $urandom; D_wdata = $urandom; D_rw = ~drw;
    D_size = 2'($urandom_range(0, 3));
    @(negedge Clk);
    total++;
    if ({busy, RamEn, F_ack, D_ack} !== 4'b1000) begin
      bad++; $display("FAIL %s c1_ctl busy/ramen/facK/dack got=%b%b%b%b exp=1000", tag, busy, RamEn, F_ack, D_ack);
    end
    total++;
    if ({Mar, Mdr, RW, WordSel} !== {ea, em, erw, ews}) begin
      bad++; $display("FAIL %s c1_capture got mar=%h mdr=%h rw=%b ws=%b exp mar=%h mdr=%h rw=%b ws=%b",
                      tag, Mar, Mdr, RW, WordSel, ea, em, erw, ews);
    end
    step();
    if (!mis) begin
      for (int i = 0; i <= dly; i++) begin
        MFC = (i == dly);
        RamOut = (i == dly) ? ro : $urandom;
        @(negedge Clk);
        total++;
        if ({RamEn, F_ack, D_ack} !== 3'b100) begin
          bad++; $display("FAIL %s access_cyc%0d ramen/fack/dack got=%b%b%b exp=100", tag, i, RamEn, F_ack, D_ack);
        end
        step();
      end
      MFC = 1'b0;
      RamOut = $urandom;
    end
    @(negedge Clk);
    total++;
    if ({F_ack, D_ack, err, RamEn} !== {!gd, gd, mis, 1'b0}) begin
      bad++; $display("FAIL %s ack fack/dack/err/ramen got=%b%b%b%b exp=%b%b%b0", tag, F_ack, D_ack, err, RamEn, !gd, gd, mis);
    end
    total++;
    if (rdata !== erd) begin bad++; $display("FAIL %s rdata got=%h exp=%h", tag, rdata, erd); end
    total++;
    if ({Mar, Mdr, busy} !== {ea, em, 1'b1}) begin
      bad++; $display("FAIL %s ack_stable got mar=%h mdr=%h busy=%b exp mar=%h mdr=%h busy=1", tag, Mar, Mdr, busy, ea, em);
    end
    F_req = 1'b0; D_req = 1'b0;
    last_data = gd;
    step();
    @(negedge Clk);
    total++;
    if ({busy, F_ack, D_ack} !== 3'b000) begin
      bad++; $display("FAIL %s back_idle busy/fack/dack got=%b%b%b exp=000", tag, busy, F_ack, D_ack);
    end
    step();
  endtask

  task automatic test_reset();
    Clr = 1'b1;
    step(); step();
    @(negedge Clk);
    total++;
    if ({F_ack, D_ack, rdata, err, busy, RamEn, RW, Mar, Mdr, WordSel} !== 104'd0) begin
      bad++; $display("FAIL reset_outputs got ack=%b%b rdata=%h err=%b busy=%b ramen=%b rw=%b mar=%h mdr=%h ws=%b exp all 0",
                      F_ack, D_ack, rdata, err, busy, RamEn, RW, Mar, Mdr, WordSel);
    end
    Clr = 1'b0;
    last_data = 1'b0;
    step();
  endtask

  task automatic test_fetch_read();
    run_txn(1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 2'd2, 32'h0, 0, 32'hE3A01005, "fetch_read");
  endtask

  // Both requests held: grants alternate, acks are four cycles apart.
  task automatic test_back_to_back(input int n, input string tag);
    int got, prev, cyc;
    logic [31:0] ro;
    ro = $urandom;
    F_addr = 32'h400; D_addr = 32'h300; D_rw = 1'b1; D_size = 2'd2; D_wdata = $urandom;
    F_req = 1'b1; D_req = 1'b1; MFC = 1'b1; RamOut = ro;
    got = 0; prev = -1; cyc = 0;
    while (got < n && cyc < 4 * n + 8) begin
      @(negedge Clk);
      if (F_ack || D_ack) begin
        total++;
        if ({F_ack, D_ack} !== {last_data, !last_data}) begin
          bad++; $display("FAIL %s order ack%0d got fack/dack=%b%b exp=%b%b", tag, got, F_ack, D_ack, last_data, !last_data);
        end
        total++;
        if (rdata !== ro || err !== 1'b0) begin
          bad++; $display("FAIL %s data ack%0d got rdata=%h err=%b exp rdata=%h err=0", tag, got, rdata, err, ro);
        end
        if (prev >= 0) begin
          total++;
          if (cyc - prev !== 4) begin bad++; $display("FAIL %s interval got=%0d exp=4", tag, cyc - prev); end
        end
        last_data = D_ack;
        prev = cyc;
        got++;
        if (got == n) begin F_req = 1'b0; D_req = 1'b0; end
      end
      step();
      cyc++;
    end
    total++;
    if (got !== n) begin bad++; $display("FAIL %s ack_count got=%0d exp=%0d", tag, got, n); end
    F_req = 1'b0; D_req = 1'b0; MFC = 1'b0;
    step();
  endtask

  task automatic test_simultaneous();
    test_reset();
    test_back_to_back(4, "simul_alternate");
    // After reset the tie again goes to data.
    test_reset();
    run_txn(1'b1, 1'b1, 32'h800, 32'h900, 1'b1, 2'd2, 32'h0, 1, $urandom, "tie_after_reset");
  endtask

  task automatic test_halfword_store();
    run_txn(1'b0, 1'b1, 32'h0, 32'h202, 1'b0, 2'd1, 32'hABCD, 2, 32'h12345678, "half_store");
  endtask

  task automatic test_misaligned();
    run_txn(1'b0, 1'b1, 32'h0, 32'h203, 1'b1, 2'd2, 32'h0, 0, 32'h0, "misaligned_word");
    run_txn(1'b0, 1'b1, 32'h0, 32'h201, 1'b0, 2'd1, 32'h55, 0, 32'h0, "misaligned_half");
    run_txn(1'b0, 1'b1, 32'h0, 32'h200, 1'b1, 2'd3, 32'h0, 0, 32'h0, "reserved_size");
    run_txn(1'b1, 1'b0, 32'h102, 32'h0, 1'b1, 2'd2, 32'h0, 0, 32'h0, "misaligned_fetch");
  endtask

  task automatic test_reset_mid();
    F_req = 1'b1; F_addr = 32'h40; MFC = 1'b0;
    step(); step(); step();   // cycle 3, in ACCESS
    Clr = 1'b1;
    step();
    @(negedge Clk);
    total++;
    if ({F_ack, D_ack, rdata, err, busy, RamEn, RW, Mar, Mdr, WordSel} !== 104'd0) begin
      bad++; $display("FAIL reset_mid_outputs got ack=%b%b busy=%b ramen=%b mar=%h rw=%b exp all 0",
                      F_ack, D_ack, busy, RamEn, Mar, RW);
    end
    Clr = 1'b0; F_req = 1'b0;
    last_data = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge Clk);
      total++;
      if ({F_ack, D_ack, busy} !== 3'b000) begin
        bad++; $display("FAIL reset_mid_no_ack cyc%0d got fack/dack/busy=%b%b%b exp=000", i, F_ack, D_ack, busy);
      end
    end
    step();
    run_txn(1'b1, 1'b0, 32'h44, 32'h0, 1'b1, 2'd2, 32'h0, 0, $urandom, "after_reset_fetch");
  endtask

  task automatic test_timeout();
    int nacc;
    D_req = 1'b1; D_addr = 32'h500; D_rw = 1'b1; D_size = 2'd2; MFC = 1'b0; RamOut = $urandom;
    step(); step();   // cycle 2, first ACCESS cycle
    D_req = 1'b0;
    nacc = 0;
    while (RamEn === 1'b1 && nacc < 40) begin
      nacc++;
      step();
    end
`ifdef MEM_TIMEOUT_EN
    @(negedge Clk);
    total++;
    if (nacc !== 4) begin bad++; $display("FAIL timeout_cycles got=%0d exp=4", nacc); end
    total++;
    if ({D_ack, F_ack, err, rdata} !== {1'b1, 1'b0, 1'b1, 32'd0}) begin
      bad++; $display("FAIL timeout_ack got dack=%b fack=%b err=%b rdata=%h exp dack=1 fack=0 err=1 rdata=0", D_ack, F_ack, err, rdata);
    end
`else
    // Without the timeout the block keeps waiting; MFC then completes it.
    total++;
    if (nacc !== 40 || busy !== 1'b1) begin
      bad++; $display("FAIL wait_forever got access_cycles=%0d busy=%b exp=40 busy=1", nacc, busy);
    end
    MFC = 1'b1;
    step();
    MFC = 1'b0;
    @(negedge Clk);
    total++;
    if ({D_ack, err, rdata} !== {1'b1, 1'b0, RamOut}) begin
      bad++; $display("FAIL late_mfc_ack got dack=%b err=%b rdata=%h exp dack=1 err=0 rdata=%h", D_ack, err, rdata, RamOut);
    end
`endif
    last_data = 1'b1;
    step(); step();
    // MFC arriving in the last allowed ACCESS cycle still completes normally.
    run_txn(1'b0, 1'b1, 32'h0, 32'h504, 1'b1, 2'd2, 32'h0, 3, 32'hCAFEF00D, "mfc_at_limit");
  endtask

  task automatic test_random(input int n);
    logic [31:0] r, fa, da;
    bit f, d;
    for (int k = 0; k < n; k++) begin
      r = $urandom;
      f = r[0]; d = r[1];
      if (!f && !d) begin f = 1'b1; d = 1'b1; end
      r  = $urandom;
      fa = (r[31:30] == 2'b00) ? r : (r & 32'hFFFF_FFFC);
      r  = $urandom;
      da = 32'h2000 + (r % 16);
      run_txn(f, d, fa, da, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
              $urandom_range(0, 3), $urandom, "random");
    end
  endtask

  initial begin
    test_reset();
    test_fetch_read();
    test_simultaneous();
    test_halfword_store();
    test_misaligned();
    test_reset_mid();
    test_timeout();
    test_back_to_back(6, "back_to_back");
    test_random(40);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
